// File: rtl/regfile_dump_controller_pkg.sv
// Shared definitions for the register-file dump sequencer: FSM encoding,
// UART byte width and the bytes-per-word helper.
package regfile_dump_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_TX = 3'd3,
        ST_DONE    = 3'd4
    } dump_state_e;

    localparam int UART_BITS = 8;

    function automatic int bytes_per_word(input int reg_bits, input int uart_bits);
        return reg_bits / uart_bits;
    endfunction

endpackage

// File: rtl/regfile_dump_controller_word_serializer.sv
// Holds one register word and presents it MSB byte first; the controller
// decides when to load a fresh word and when to advance to the next byte.
module regfile_dump_controller_word_serializer
    import regfile_dump_controller_pkg::*;
#(
    parameter int WORD_BITS = 32,
    parameter int BYTE_BITS = UART_BITS
) (
    input  logic                 i_clock,
    input  logic                 i_soft_reset,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic [WORD_BITS-1:0] i_word,
    output logic [BYTE_BITS-1:0] o_byte,
    output logic                 o_last
);

    localparam int BPW   = bytes_per_word(WORD_BITS, BYTE_BITS);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (i_load) begin
            shift_d = i_word;
            idx_d   = '0;
        end else if (i_shift) begin
            shift_d = shift_q << BYTE_BITS;
            idx_d   = idx_q + 1'b1;
        end
    end

    // The shift register is reset too, so o_tx_data reads zero while in reset.
    always_ff @(posedge i_clock or posedge i_soft_reset) begin
        if (i_soft_reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign o_byte = shift_q[WORD_BITS-1 -: BYTE_BITS];
    assign o_last = (idx_q == LAST_IDX);

endmodule

// File: rtl/regfile_dump_controller.sv
// Debug sequencer: freezes the pipeline, borrows register-file read port A
// and streams every register to the UART transmitter, MSB byte first.
module regfile_dump_controller
    import regfile_dump_controller_pkg::*;
#(
    parameter int CANT_REGISTROS      = 32,
    parameter int CANT_BITS_REGISTROS = 32,
    parameter int CANT_BITS_ADDR_REG  = 5,
    parameter int CANT_BITS_UART      = UART_BITS
) (
    input  logic                           i_clock,
    input  logic                           i_soft_reset,
    input  logic                           i_dump_request,
    input  logic [CANT_BITS_ADDR_REG-1:0]  i_pipe_reg_A,
    input  logic [CANT_BITS_ADDR_REG-1:0]  i_pipe_reg_B,
    output logic [CANT_BITS_ADDR_REG-1:0]  o_reg_A,
    output logic [CANT_BITS_ADDR_REG-1:0]  o_reg_B,
    input  logic [CANT_BITS_REGISTROS-1:0] i_data_A,
    output logic                           o_pipeline_stall,
    output logic [CANT_BITS_UART-1:0]      o_tx_data,
    output logic                           o_tx_start,
    input  logic                           i_tx_done,
    output logic                           o_busy,
    output logic                           o_dump_done
);

    localparam logic [CANT_BITS_ADDR_REG-1:0] LAST_REG = CANT_BITS_ADDR_REG'(CANT_REGISTROS - 1);

    dump_state_e                   state_q, state_d;
    logic [CANT_BITS_ADDR_REG-1:0] reg_idx_q, reg_idx_d;
    logic                          ser_load, ser_shift, ser_last;

    always_comb begin
        state_d   = state_q;
        reg_idx_d = reg_idx_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_dump_request) begin
                    state_d   = ST_READ;
                    reg_idx_d = '0;
                end
            end
            ST_READ: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    if (!ser_last) begin
                        ser_shift = 1'b1;
                        state_d   = ST_SEND;
                    end else if (reg_idx_q == LAST_REG) begin
                        state_d = ST_DONE;
                    end else begin
                        reg_idx_d = reg_idx_q + 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge values computed above, independent of process ordering.
    always_ff @(posedge i_clock or posedge i_soft_reset) begin
        if (i_soft_reset) begin
            state_q   <= ST_IDLE;
            reg_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            reg_idx_q <= reg_idx_d;
        end
    end

    regfile_dump_controller_word_serializer #(
        .WORD_BITS (CANT_BITS_REGISTROS),
        .BYTE_BITS (CANT_BITS_UART)
    ) u_serializer (
        .i_clock      (i_clock),
        .i_soft_reset (i_soft_reset),
        .i_load       (ser_load),
        .i_shift      (ser_shift),
        .i_word       (i_data_A),
        .o_byte       (o_tx_data),
        .o_last       (ser_last)
    );

    // Everything below decodes straight from state_q so stall and mux switch together.
    assign o_busy           = (state_q != ST_IDLE);
    assign o_pipeline_stall = o_busy;
    assign o_tx_start       = (state_q == ST_SEND);
    assign o_dump_done      = (state_q == ST_DONE);
    assign o_reg_A          = o_busy ? reg_idx_q : i_pipe_reg_A;
    assign o_reg_B          = i_pipe_reg_B;

endmodule

// File: tb/tb_regfile_dump_controller.sv
// Directed bench: register file and UART TX are modelled here; each dump is
// checked byte by byte against R[n] = 0xA0B0C000 + n.
module tb_regfile_dump_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dump_req = 1'b0;
    logic [4:0]  pipe_a = 5'd3;
    logic [4:0]  pipe_b = 5'd9;
    logic [4:0]  reg_a, reg_b;
    logic [31:0] data_a;
    logic        stall, tx_start, busy, dump_done;
    logic [7:0]  tx_data;
    logic        tx_model = 1'b0;
    logic        tx_spur  = 1'b0;
    logic        tx_hold  = 1'b0;
    logic        tx_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mux_err = 0;
    int          done_cnt = 0;
    int          tx_cnt = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  bytes[$];

    always #5 clk = ~clk;

    assign data_a  = 32'hA0B0C000 + {27'd0, reg_a};
    assign tx_done = tx_model | tx_spur | tx_hold;

    regfile_dump_controller dut (
        .i_clock          (clk),
        .i_soft_reset     (rst),
        .i_dump_request   (dump_req),
        .i_pipe_reg_A     (pipe_a),
        .i_pipe_reg_B     (pipe_b),
        .o_reg_A          (reg_a),
        .o_reg_B          (reg_b),
        .i_data_A         (data_a),
        .o_pipeline_stall (stall),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .i_tx_done        (tx_done),
        .o_busy           (busy),
        .o_dump_done      (dump_done)
    );

    // UART TX model: one-cycle done pulse sampled on the 3rd edge after start.
    initial forever begin
        @(posedge clk);
        #1;
        tx_model = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_model = 1'b1;
        end
        if (tx_start === 1'b1) tx_cnt = 2;
    end

    // Byte capture plus continuous mux/stall/handshake sanity tracking.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (tx_start === 1'b1) begin
                if (reg_a !== 5'(bytes.size() / 4)) mux_err++;
                if (prev_start) mux_err++;
                bytes.push_back(tx_data);
            end
            if (busy === 1'b1 && reg_b !== pipe_b) mux_err++;
            if (stall !== busy) mux_err++;
            if (dump_done === 1'b1) done_cnt++;
            prev_start = tx_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_dump();
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check("lat_read_busy", busy, 1'b1);
        check("lat_read_nostart", tx_start, 1'b0);
        check("lat_read_reg_a", reg_a, 5'd0);
        @(negedge clk);
        check("lat_send_start", tx_start, 1'b1);
        check("lat_send_byte", tx_data, 8'hA0);
    endtask

    task automatic wait_bytes(input int n);
        int guard = 0;
        while (bytes.size() < n && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_byte", bytes.size() >= n, 1'b1);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (dump_done !== 1'b1 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", dump_done, 1'b1);
        @(negedge clk);
        check("done_one_cycle", dump_done, 1'b0);
        check("stall_released", stall, 1'b0);
        check("busy_released", busy, 1'b0);
    endtask

    task automatic check_bytes();
        logic [7:0] exp;
        check("byte_count", bytes.size(), 32'd128);
        for (int i = 0; i < bytes.size(); i++) begin
            case (i % 4)
                0:       exp = 8'hA0;
                1:       exp = 8'hB0;
                2:       exp = 8'hC0;
                default: exp = 8'(i / 4);
            endcase
            check($sformatf("byte[%0d]", i), bytes[i], exp);
        end
        check("mux_errors", mux_err, 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_start", tx_start, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_done", dump_done, 1'b0);
        check("rst_reg_a", reg_a, 5'd3);
        @(negedge clk);
        rst = 1'b0;

        // Idle pass-through and spurious done in IDLE
        @(negedge clk);
        check("idle_reg_a", reg_a, 5'd3);
        check("idle_reg_b", reg_b, 5'd9);
        tx_spur = 1'b1;
        repeat (3) @(negedge clk);
        tx_spur = 1'b0;
        check("spur_idle_busy", busy, 1'b0);
        check("spur_idle_nobytes", bytes.size(), 32'd0);

        // Full dump with a request pulsed while busy on register 4
        start_dump();
        wait_bytes(17);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check("busyreq_still_busy", busy, 1'b1);
        check("busyreq_reg_a", reg_a, 5'd4);
        check("busyreq_reg_b", reg_b, 5'd9);
        wait_done();
        repeat (4) @(negedge clk);
        check_bytes();
        check("done_count_1", done_cnt, 32'd1);
        check("no_restart", busy, 1'b0);

        // i_tx_done held high for the whole dump
        bytes.delete();
        tx_hold = 1'b1;
        start_dump();
        wait_done();
        tx_hold = 1'b0;
        repeat (4) @(negedge clk);
        check_bytes();
        check("done_count_2", done_cnt, 32'd2);

        // Reset at register 10, byte 2
        bytes.delete();
        pipe_a = 5'd7;
        start_dump();
        wait_bytes(43);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_start", tx_start, 1'b0);
        check("midrst_data", tx_data, 8'h00);
        check("midrst_done", dump_done, 1'b0);
        check("midrst_reg_a", reg_a, 5'd7);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_done", done_cnt, 32'd2);
        check("midrst_idle", busy, 1'b0);

        // Restart after reset begins again from R[0]
        bytes.delete();
        start_dump();
        wait_done();
        repeat (4) @(negedge clk);
        check_bytes();
        check("done_count_3", done_cnt, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_controller.md
Name: regfile_dump_controller

Overview:
- Debug sequencer that shares register-file read port A between the ID stage and the debug unit.
- On request: freezes the pipeline, walks every register through port A, and streams each word to the UART transmitter one byte at a time with a start/done handshake.
- Sits between top_id's register file, the pipeline stall logic and the debug UART TX.

Parameters:
- CANT_REGISTROS, 32, number of registers dumped.
- CANT_BITS_REGISTROS, 32, register width; must be a multiple of CANT_BITS_UART.
- CANT_BITS_ADDR_REG, 5, register address width (clogb2(CANT_REGISTROS-1)).
- CANT_BITS_UART, 8, UART data width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_soft_reset  in  1  asynchronous, active-high reset.
- i_dump_request  in  1  start dump; sampled only in IDLE.
- i_pipe_reg_A  in  CANT_BITS_ADDR_REG  pipeline rs address.
- i_pipe_reg_B  in  CANT_BITS_ADDR_REG  pipeline rt address.
- o_reg_A  out  CANT_BITS_ADDR_REG  to register_file i_reg_A.
- o_reg_B  out  CANT_BITS_ADDR_REG  to register_file i_reg_B.
- i_data_A  in  CANT_BITS_REGISTROS  register_file o_data_A; combinational read.
- o_pipeline_stall  out  1  freeze PC/IF/ID while high.
- o_tx_data  out  CANT_BITS_UART  byte to UART TX.
- o_tx_start  out  1  one-cycle start pulse to UART TX.
- i_tx_done  in  1  UART TX finished current byte.
- o_busy  out  1  dump in progress.
- o_dump_done  out  1  one-cycle pulse after the last byte.

Behaviour:
- Reset (async, active-high), all registers:
  - state=IDLE, reg index=0, byte index=0, shift register=0.
  - o_tx_start=0, o_tx_data=0, o_dump_done=0.
  - o_busy=0, o_pipeline_stall=0.
  - Reset overrides any simultaneous input.
- FSM states: IDLE, READ, SEND, WAIT_TX, DONE.
- IDLE:
  - o_reg_A=i_pipe_reg_A, o_reg_B=i_pipe_reg_B (combinational pass-through).
  - i_dump_request=1 at an edge -> READ, reg index=0.
- READ (one cycle):
  - o_reg_A=reg index.
  - At the edge, capture i_data_A into the shift register, byte index=0 -> SEND.
- SEND (one cycle):
  - o_tx_start=1.
  - o_tx_data=shift register MSB byte (bits [CANT_BITS_REGISTROS-1 -: CANT_BITS_UART]); byte order is MSB first.
  - -> WAIT_TX.
- WAIT_TX:
  - Hold o_tx_data; o_tx_start=0.
  - On i_tx_done=1:
    - If byte index < BYTES_PER_WORD-1: shift register <<= CANT_BITS_UART, byte index+1 -> SEND.
    - Else if reg index = CANT_REGISTROS-1 -> DONE.
    - Else reg index+1 -> READ.
- DONE (one cycle): o_dump_done=1 -> IDLE.
- o_busy and o_pipeline_stall are both high in every state except IDLE, and are decoded from the state register (glitch-free, same cycle as the mux switch).
- In any non-IDLE state: o_reg_A=reg index; o_reg_B=i_pipe_reg_B unchanged.
- Latency:
  - Request sampled at edge 0 -> READ in cycle 1 -> first o_tx_start in cycle 2.
  - Per byte: 2 cycles + TX time.
  - Total bytes: CANT_REGISTROS*BYTES_PER_WORD (128 at defaults).
- Boundaries:
  - i_dump_request while busy: ignored, not queued.
  - i_tx_done outside WAIT_TX: ignored.
  - i_tx_done arriving in the cycle right after SEND: valid.
  - i_tx_done held high across cycles: each WAIT_TX entry consumes it once; SEND always intervenes, so no byte is skipped.
  - reg index never wraps; terminates at CANT_REGISTROS-1.
  - Reset mid-dump: immediate IDLE, stall released, no o_dump_done.
- Register-file write port is untouched; the stall prevents WB writes during the dump.

Decomposition:
- Shared header (debug_defs.vh):
  - FSM state encodings (3-bit localparams).
  - BYTES_PER_WORD = CANT_BITS_REGISTROS/CANT_BITS_UART.
  - UART width constant, reused by the debug unit.
- One sub-module: word_serializer.
  - Holds the shift register and byte index; load/shift/last outputs.
  - Controller keeps the FSM, reg index and mux.

Test Plan:
- Reset values: assert reset mid-run -> all outputs 0 in the same cycle, o_reg_A follows i_pipe_reg_A=5'd7 -> 7.
- Full dump:
  - Stimulus: regs preloaded with R[n]=0xA0B0C000+n; model TX asserts i_tx_done 3 cycles after each start.
  - Required: exactly 128 o_tx_start pulses, bytes A0,B0,C0,00,A0,B0,C0,01,... ending ...,C0,1F; then one o_dump_done pulse; stall low on the next cycle.
- Pass-through: idle, i_pipe_reg_A=3, i_pipe_reg_B=9 -> o_reg_A=3, o_reg_B=9; during the dump o_reg_A=index, o_reg_B=9.
- Busy request: pulse i_dump_request during register 4 -> no restart; total pulses remain 128.
- Handshake edges:
  - i_tx_done held high continuously -> still 128 distinct bytes, each separated by SEND.
  - Spurious i_tx_done in IDLE/READ -> no effect.
- Reset at register 10, byte 2: idle immediately, no o_dump_done; a new request restarts from R[0] byte A0.
